// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared types for the APB4 master bridge
package apb_master_bridge_pkg;
  localparam int XLEN       = 32;
  localparam int PADDR_SIZE = 32;
  localparam int STRB_W     = XLEN / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} ApbMstState;

  typedef struct packed {
    logic [PADDR_SIZE-1:0] addr;
    logic                  write;
    logic [XLEN-1:0]       wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } ApbCmd;

  typedef struct packed {
    logic [PADDR_SIZE-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [XLEN-1:0]       pwdata;
    logic [STRB_W-1:0]     pstrb;
  } ApbReq;

  typedef struct packed {
    logic [XLEN-1:0] prdata;
    logic            pready;
    logic            pslverr;
  } ApbResp;
endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase stall counter; expired once TIMEOUT-1 stalled cycles have elapsed
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready to APB4 master bridge, one transfer in flight
// Optional ACCESS-phase abort enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PADDR_SIZE-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic [STRB_W-1:0]     req_strb_i,
  input  logic [2:0]            req_prot_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic                  resp_err_o,
  output ApbReq                 apb_req_o,
  input  ApbResp                apb_resp_i
);
  ApbMstState      state_q, state_d;
  ApbCmd           cmd_q, cmd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            resp_valid_q, resp_valid_d;
  logic            timeout_hit;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == SETUP),
    .tick_i   ((state_q == ACCESS) && !apb_resp_i.pready),
    .expired_o(timeout_hit)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          cmd_d.addr  = req_addr_i;
          cmd_d.write = req_write_i;
          cmd_d.prot  = req_prot_i;
          // Reads drive no strobes and leave pwdata at the last written value.
          cmd_d.strb  = req_write_i ? req_strb_i : '0;
          if (req_write_i) begin
            cmd_d.wdata = req_wdata_i;
          end
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A pready arriving on the expiry cycle still completes normally.
        if (apb_resp_i.pready) begin
          rdata_d = cmd_q.write ? '0 : apb_resp_i.prdata;
          err_d   = apb_resp_i.pslverr;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    psel_d       = (state_d == SETUP) || (state_d == ACCESS);
    penable_d    = (state_d == ACCESS);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  assign apb_req_o.paddr   = cmd_q.addr;
  assign apb_req_o.pprot   = cmd_q.prot;
  assign apb_req_o.psel    = psel_q;
  assign apb_req_o.penable = penable_q;
  assign apb_req_o.pwrite  = cmd_q.write;
  assign apb_req_o.pwdata  = cmd_q.wdata;
  assign apb_req_o.pstrb   = cmd_q.strb;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge (APB_TIMEOUT_EN optional)
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  ApbReq       apb_req;
  ApbResp      apb_resp = '0;

  always #5 clk = ~clk;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .req_prot_i  (req_prot),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_err_o  (resp_err),
    .apb_req_o   (apb_req),
    .apb_resp_i  (apb_resp)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Slave plan: pready on ACCESS cycle index plan_wait (0-based), or never.
  int          plan_wait = 0;
  logic        plan_err = 1'b0;
  logic [31:0] plan_rdata = '0;
  logic        plan_never = 1'b0;
  int          acc_i = 0;

  always @(negedge clk) begin
    if (apb_req.psel && apb_req.penable) begin
      apb_resp.pready = !plan_never && (acc_i == plan_wait);
      acc_i++;
    end else begin
      apb_resp.pready = 1'b0;
      acc_i = 0;
    end
    apb_resp.pslverr = apb_resp.pready ? plan_err : 1'b1;
    apb_resp.prdata  = apb_resp.pready ? plan_rdata : 32'hBAD0_0001;
  end

  // Transaction-timeline model: accept edge m_n, m_acc ACCESS cycles, then RESP until handshake.
  int          cyc = 0;
  logic        m_live = 1'b0;
  logic        m_busy = 1'b0;
  int          m_n = 0;
  int          m_acc = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic [2:0]  m_prot = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live = 1'b0; m_busy = 1'b0;
      m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0; m_write = 1'b0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (cyc >= m_n + m_acc + 2 && resp_ready) m_busy = 1'b0;
      end else if (m_live && req_valid) begin
        m_busy  = 1'b1;
        m_n     = cyc;
        m_acc   = plan_never ? TO : plan_wait + 1;
        m_addr  = req_addr;
        m_write = req_write;
        m_prot  = req_prot;
        m_strb  = req_write ? req_strb : 4'h0;
        if (req_write) m_wdata = req_wdata;
        m_err   = plan_never ? 1'b1 : plan_err;
        m_rdata = (plan_never || req_write) ? 32'h0 : plan_rdata;
      end
      m_live = 1'b1;
    end
  end

  logic cmp_en = 1'b0;
  logic ph_s, ph_a, ph_r;

  always @(negedge clk) begin
    if (cmp_en) begin
      ph_s = m_busy && (cyc == m_n);
      ph_a = m_busy && (cyc > m_n) && (cyc <= m_n + m_acc);
      ph_r = m_busy && (cyc > m_n + m_acc);
      chk("req_ready", 64'(req_ready), 64'(m_live && !m_busy));
      chk("psel", 64'(apb_req.psel), 64'(ph_s || ph_a));
      chk("penable", 64'(apb_req.penable), 64'(ph_a));
      chk("resp_valid", 64'(resp_valid), 64'(ph_r));
      chk("paddr", 64'(apb_req.paddr), 64'(m_addr));
      chk("pwrite", 64'(apb_req.pwrite), 64'(m_write));
      chk("pprot", 64'(apb_req.pprot), 64'(m_prot));
      chk("pstrb", 64'(apb_req.pstrb), 64'(m_strb));
      chk("pwdata", 64'(apb_req.pwdata), 64'(m_wdata));
      if (ph_r) begin
        chk("resp_rdata", 64'(resp_rdata), 64'(m_rdata));
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int wt,
                      input logic er, input logic [31:0] rd, input logic nv);
    logic seen;
    seen = 1'b0;
    plan_wait = wt; plan_err = er; plan_rdata = rd; plan_never = nv;
    req_addr = addr; req_write = wr; req_wdata = wdata; req_strb = strb; req_prot = prot;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      seen = req_ready;
    end
    chk("cmd_accepted", 64'(seen), 64'(1));
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_accept(output int edges);
    logic seen;
    seen = 1'b0;
    edges = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      edges++;
      seen = req_ready;
    end
    chk("pending_accepted", 64'(seen), 64'(1));
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("resp_seen", 64'(resp_valid), 64'(1));
  endtask

  task automatic handshake(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int edges;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_psel", 64'(apb_req.psel), 64'(0));
    chk("rst_paddr", 64'(apb_req.paddr), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    cmp_en = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 64'(req_ready), 64'(1));

    // Zero-wait read.
    send(32'h0000_0040, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b010, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("t1_pstrb_setup", 64'(apb_req.pstrb), 64'(0));
    wait_resp(lat);
    chk("t1_resp_cycle", 64'(lat + 1), 64'(3));
    chk("t1_rdata", 64'(resp_rdata), 64'(32'hDEAD_BEEF));
    chk("t1_err", 64'(resp_err), 64'(0));
    handshake(0);

    // Write with three wait states.
    send(32'h0000_1000, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 3, 1'b0, 32'h0, 1'b0);
    wait_resp(lat);
    chk("t2_resp_cycle", 64'(lat + 1), 64'(6));
    chk("t2_rdata", 64'(resp_rdata), 64'(0));
    chk("t2_paddr", 64'(apb_req.paddr), 64'(32'h0000_1000));
    chk("t2_pwdata", 64'(apb_req.pwdata), 64'(32'h1234_5678));
    handshake(0);

    // Slave error, held response, pending second command.
    send(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'b001, 1, 1'b1, 32'h5555_AAAA, 1'b0);
    wait_resp(lat);
    chk("t3_err", 64'(resp_err), 64'(1));
    chk("t3_rdata", 64'(resp_rdata), 64'(32'h5555_AAAA));
    plan_wait = 0; plan_err = 1'b0; plan_rdata = 32'hCAFE_F00D;
    req_addr = 32'h0000_3000; req_write = 1'b0; req_prot = 3'b000; req_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("t3_hold_ready", 64'(req_ready), 64'(0));
      chk("t3_hold_err", 64'(resp_err), 64'(1));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    wait_accept(edges);
    chk("t3_accept_after_hs", 64'(edges), 64'(1));
    #1 req_valid = 1'b0;
    wait_resp(lat);
    chk("t3b_rdata", 64'(resp_rdata), 64'(32'hCAFE_F00D));
    handshake(0);

    // Write with all-zero strobes still goes out on the bus.
    send(32'h0000_0044, 1'b1, 32'hA5A5_A5A5, 4'h0, 3'b100, 0, 1'b0, 32'h0, 1'b0);
    wait_resp(lat);
    chk("t4_rdata", 64'(resp_rdata), 64'(0));
    chk("t4_pwdata", 64'(apb_req.pwdata), 64'(32'hA5A5_A5A5));
    handshake(0);

    // Back-to-back commands with resp_ready held high: 4-cycle spacing.
    send(32'h0000_0080, 1'b0, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h1111_2222, 1'b0);
    req_addr = 32'h0000_0084; req_valid = 1'b1; resp_ready = 1'b1;
    wait_accept(edges);
    chk("t5_accept_spacing", 64'(edges), 64'(4));
    #1 req_valid = 1'b0; resp_ready = 1'b0;
    wait_resp(lat);
    chk("t5_rdata", 64'(resp_rdata), 64'(32'h1111_2222));
    handshake(0);

`ifdef APB_TIMEOUT_EN
    send(32'h0000_0090, 1'b0, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h9999_9999, 1'b1);
    wait_resp(lat);
    chk("t6_timeout_cycle", 64'(lat + 1), 64'(10));
    chk("t6_timeout_err", 64'(resp_err), 64'(1));
    chk("t6_timeout_rdata", 64'(resp_rdata), 64'(0));
    chk("t6_psel_dropped", 64'(apb_req.psel), 64'(0));
    handshake(1);
    send(32'h0000_0094, 1'b0, 32'h0, 4'hF, 3'b000, 7, 1'b0, 32'h7777_8888, 1'b0);
    wait_resp(lat);
    chk("t7_last_cycle_cycle", 64'(lat + 1), 64'(10));
    chk("t7_last_cycle_err", 64'(resp_err), 64'(0));
    chk("t7_last_cycle_rdata", 64'(resp_rdata), 64'(32'h7777_8888));
    handshake(0);
`else
    send(32'h0000_0090, 1'b0, 32'h0, 4'hF, 3'b000, 12, 1'b0, 32'h9999_9999, 1'b0);
    wait_resp(lat);
    chk("t6_long_wait_cycle", 64'(lat + 1), 64'(15));
    chk("t6_long_wait_err", 64'(resp_err), 64'(0));
    chk("t6_long_wait_rdata", 64'(resp_rdata), 64'(32'h9999_9999));
    handshake(0);
`endif

    // Reset asserted mid-ACCESS, between clock edges.
    send(32'h0000_00A0, 1'b0, 32'h0, 4'hF, 3'b000, 5, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t8_async_psel", 64'(apb_req.psel), 64'(0));
    chk("t8_async_penable", 64'(apb_req.penable), 64'(0));
    chk("t8_async_resp_valid", 64'(resp_valid), 64'(0));
    chk("t8_async_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t8_ready_after", 64'(req_ready), 64'(1));
    chk("t8_no_stale_resp", 64'(resp_valid), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    send(32'h0000_00B0, 1'b0, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0BAD_CAFE, 1'b0);
    wait_resp(lat);
    chk("t8_post_reset_rdata", 64'(resp_rdata), 64'(32'h0BAD_CAFE));
    handshake(0);
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB4 initiator that turns a simple valid/ready command channel into single APB4 transfers and returns read data and error status on a valid/ready response channel. It sits between core-side MMIO/uncached logic and the peripheral APB fabric, and drives the master end of an `ApbIO` bundle (`ApbReq` out, `ApbResp` in). It handles one outstanding transfer at a time.

## Interface
- `TIMEOUT`, 256: ACCESS-phase cycles allowed before abort; only used with `APB_TIMEOUT_EN`; legal range 2..65536.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: command valid.
- `req_ready` output 1: bridge can accept a command.
- `req_addr` input `PADDR_SIZE`: target address.
- `req_write` input 1: 1 = write, 0 = read.
- `req_wdata` input `XLEN`: write data.
- `req_strb` input `XLEN/8`: write byte strobes.
- `req_prot` input 3: protection attributes.
- `resp_valid` output 1: response valid.
- `resp_ready` input 1: consumer accepts the response.
- `resp_rdata` output `XLEN`: read data; 0 for writes and aborted transfers.
- `resp_err` output 1: `pslverr` seen, or timeout.
- `apb` `ApbIO.master`: `req` driven, `resp` sampled.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch addr, write, wdata, prot and strb, then go to SETUP.
  - For reads, `pstrb` is forced to 0.
  - For reads, `pwdata` is held at its previous value.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - If `pready` is 1 when sampled, capture `prdata` (reads only) and `pslverr` into `resp_err`, then go to RESP.
  - `pslverr` is ignored unless `pready` is 1.
- RESP:
  - `resp_valid`=1; `psel`=0, `penable`=0.
  - Hold `resp_rdata` and `resp_err` stable until `resp_valid && resp_ready`, then go to IDLE.
- `paddr`, `pwrite`, `pprot`, `pwdata` and `pstrb` stay constant from SETUP until the next accepted command. They are not returned to 0 between transfers.
- Write with all-zero `req_strb`: issued normally on APB.
- Reset asserted mid-transfer: the transfer is abandoned immediately and asynchronously. No response is produced.
- Reset values:
  - `req_ready`=0 while reset is asserted, 1 in the first cycle after release.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - All `apb.req` fields = 0.
  - State = IDLE.

## Timing
- Command accepted at edge N: SETUP in cycle N+1, ACCESS in cycle N+2.
- With `pready`=1 in the first ACCESS cycle, `resp_valid` rises in cycle N+3.
- Each wait state adds one cycle.
- `req_ready` is 0 from the accept edge until the cycle after the response handshake. Minimum spacing between command accepts is 4 cycles.
- No combinational path from any `apb.resp` field to any output. All outputs come from registers.
- A `req_valid` that arrives while busy is not dropped. It stays pending until `req_ready`.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready`=0.
  - When the counter reaches `TIMEOUT-1` with `pready` still 0, the bridge leaves ACCESS and goes to RESP with `resp_err`=1, `resp_rdata`=0.
  - `psel` and `penable` drop in that same transition.
  - If `pready`=1 arrives in the same cycle as the timeout, `pready` wins: the normal completion is used.
- `APB_TIMEOUT_EN` undefined:
  - No counter exists and `TIMEOUT` is ignored.
  - ACCESS waits indefinitely for `pready`.

## Structure
- Shared package holds:
  - The `ApbMstState` enum (IDLE/SETUP/ACCESS/RESP).
  - An `ApbCmd` packed struct (addr, write, wdata, strb, prot) used for the latched command.
- Timeout logic lives in one sub-module, `apb_timeout_cnt` (inputs: clear, tick; output: expired). It is instantiated only under `APB_TIMEOUT_EN`.

## Test plan
- Read, zero-wait slave returning `prdata`=0xDEADBEEF: accept at N gives `resp_valid` at N+3 with `resp_rdata`=0xDEADBEEF, `resp_err`=0. `pstrb`=0 throughout the transfer.
- Write addr 0x1000, data 0x12345678, strb 0xF, slave inserts 3 wait states: SETUP lasts 1 cycle, ACCESS lasts 4 cycles, `resp_valid` at N+6. `resp_rdata`=0, bus fields stable across all ACCESS cycles.
- Slave responds with `pready`=1, `pslverr`=1: `resp_err`=1. With `resp_ready` held low 5 cycles, the response is held stable and `req_ready` stays 0. A second command waiting on `req_valid` is accepted only after the response handshake.
- `APB_TIMEOUT_EN`, `TIMEOUT`=8, slave never asserts `pready`: ACCESS lasts 8 cycles, then `resp_err`=1, `resp_rdata`=0, `psel` drops. Repeat with `pready` arriving on the 8th cycle: normal completion, `resp_err`=0.
- Reset pulled low during ACCESS: `psel`, `penable` and `resp_valid` go to 0 without waiting for a clock edge. After release the bridge is in IDLE with `req_ready`=1 and produces no stale response.
